// File: rtl/pipe_div_seq_if.sv
// Request/response bundle between the EXE-stage divide sequencer and its pipeline
// control/HI-LO write-back client.
interface pipe_div_seq_if #(parameter int WIDTH = 32);
    logic             i_start;
    logic             i_sign;
    logic             i_flush;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_stall;
    logic             o_busy;
    logic [WIDTH-1:0] o_quot;
    logic [WIDTH-1:0] o_rem;
    logic             o_w_lo;
    logic             o_w_hi;

    modport master (
        output i_start, i_sign, i_flush, i_dividend, i_divisor,
        input  o_stall, o_busy, o_quot, o_rem, o_w_lo, o_w_hi
    );
    modport slave (
        input  i_start, i_sign, i_flush, i_dividend, i_divisor,
        output o_stall, o_busy, o_quot, o_rem, o_w_lo, o_w_hi
    );
endinterface

// File: rtl/pipe_div_seq.sv
// MIPS DIV/DIVU sequencer: restoring divider, one quotient bit per cycle, stalls the
// pipeline while iterating and pulses the HI/LO write enables on completion.
module pipe_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    pipe_div_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dv;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_wen;

    logic             w_accept;
    logic             w_dd_neg;
    logic             w_dv_neg;
    logic [WIDTH-1:0] w_dd_abs;
    logic [WIDTH-1:0] w_dv_abs;
    logic [WIDTH:0]   w_sh_r;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_nr;
    logic [WIDTH-1:0] w_nq;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    assign w_accept = (r_state == S_IDLE) && bus.i_start && !bus.i_flush;
    assign w_dd_neg = bus.i_sign && bus.i_dividend[WIDTH-1];
    assign w_dv_neg = bus.i_sign && bus.i_divisor[WIDTH-1];
    assign w_dd_abs = w_dd_neg ? -bus.i_dividend : bus.i_dividend;
    assign w_dv_abs = w_dv_neg ? -bus.i_divisor  : bus.i_divisor;

    // The shifted remainder needs the extra top bit; after a successful subtract the
    // result is below the divisor, so the low WIDTH bits of the difference suffice.
    assign w_sh_r  = {r_r, r_q[WIDTH-1]};
    assign w_ge    = w_sh_r >= {1'b0, r_dv};
    assign w_diff  = w_sh_r[WIDTH-1:0] - r_dv;
    assign w_nr    = w_ge ? w_diff : w_sh_r[WIDTH-1:0];
    assign w_nq    = {r_q[WIDTH-2:0], w_ge};
    assign w_q_fin = r_neg_q ? -w_nq : w_nq;
    assign w_r_fin = r_neg_r ? -w_nr : w_nr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_dv    <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.i_divisor == '0) begin
                            r_quot  <= '1;
                            r_rem   <= bus.i_dividend;
                            r_wen   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_r     <= '0;
                            r_q     <= w_dd_abs;
                            r_dv    <= w_dv_abs;
                            r_neg_q <= bus.i_sign && (bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1]);
                            r_neg_r <= w_dd_neg;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_r   <= w_nr;
                        r_q   <= w_nq;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_quot  <= w_q_fin;
                            r_rem   <= w_r_fin;
                            r_wen   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A flush arriving in the DONE cycle still has to suppress the HI/LO write.
    assign bus.o_w_lo  = r_wen && !bus.i_flush;
    assign bus.o_w_hi  = r_wen && !bus.i_flush;
    assign bus.o_busy  = (r_state != S_IDLE);
    assign bus.o_stall = w_accept || (r_state == S_RUN);
    assign bus.o_quot  = r_quot;
    assign bus.o_rem   = r_rem;
endmodule
